// File: rtl/i2c_master_read_collector_pkg.sv
// Shared constants for the I2C master read collector: FSM state encodings,
// ACK/NACK bit values and a small saturating-counter helper.
package i2c_master_read_collector_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_STORE = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Value driven on SDA during the acknowledge bit
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // 4-bit increment that sticks at 15 so a runaway load stream cannot wrap
  // back to a count that looks like a valid byte.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_master_read_collector_rx_fifo.sv
// Small synchronous FIFO for received bytes. The head entry is kept in its
// own register so the output does not depend on the read pointer, and it
// keeps its last value once the FIFO drains. A push is accepted while full
// when a pop happens in the same cycle.
module i2c_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = head_q;
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign rd_next   = rd_ptr_q + 1'b1;

  // Next count and next head value
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (do_push && !do_pop) count_d = count_q + ONE_CNT;
    if (do_pop && !do_push) count_d = count_q - ONE_CNT;
    if (do_pop) begin
      if (count_q > ONE_CNT)  head_d = mem_q[rd_next];
      else if (do_push)       head_d = push_data;
    end else if (do_push && empty) begin
      head_d = push_data;
    end
  end

  // Storage array; contents are don't-care until counted valid
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/i2c_master_read_collector.sv
// Sequencer/deserializer behind the I2C master read-byte stage. It runs the
// read-byte stage, assembles each byte MSB-first, requests ACK (NACK on the
// final byte) from the bit-send stage and buffers bytes for the host.
//
// Host handshake: rx_valid is high while the FIFO holds a byte and rx_data
// shows that byte; a byte is consumed on every rising clock edge where
// rx_valid and rx_ready are both high. rx_valid never depends on rx_ready.
module i2c_master_read_collector
  import i2c_master_read_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             frame_err,
  output logic             rb_go,
  input  logic             rb_finish,
  input  logic             rb_load,
  input  logic             rb_data,
  output logic             ack_go,
  output logic             ack_value,
  input  logic             ack_finish,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [2:0]       dbg_state
);

  logic [2:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             frame_err_q, frame_err_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign fifo_pop  = rx_valid & rx_ready;
  assign rx_valid  = ~fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rb_go     = (state_q == ST_READ);
  assign ack_go    = (state_q == ST_ACK);
  assign ack_value = ((state_q == ST_ACK) && (remaining_q == '0)) ? I2C_NACK : I2C_ACK;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

  // FSM next-state, shifter and counter updates
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    remaining_d = remaining_q;
    frame_err_d = frame_err_q;
    fifo_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_err_d = 1'b0;
          if (byte_count == '0) begin
            state_d = ST_DONE;
          end else begin
            remaining_d = byte_count;
            shift_d     = '0;
            bit_cnt_d   = '0;
            state_d     = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (rb_load) begin
          shift_d   = {shift_q[6:0], rb_data};
          bit_cnt_d = sat_inc4(bit_cnt_q);
        end
        if (rb_finish) begin
          // The finishing cycle normally carries the 8th load itself
          frame_err_d = frame_err_q | ((5'(bit_cnt_q) + 5'(rb_load)) != 5'd8);
          state_d     = ST_STORE;
        end
      end
      ST_STORE: begin
        // A full FIFO is still writable when the host pops this cycle
        if (!fifo_full || fifo_pop) begin
          fifo_push   = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = ST_ACK;
        end
      end
      ST_ACK: begin
        if (ack_finish) state_d = ST_GAP;
      end
      ST_GAP: begin
        bit_cnt_d = '0;
        state_d   = (remaining_q == '0) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over everything in an active state; the partial byte is dropped
    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d     = ST_DONE;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      remaining_d = remaining_q;
      frame_err_d = frame_err_q;
      fifo_push   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      remaining_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      remaining_q <= remaining_d;
      frame_err_q <= frame_err_d;
    end
  end

  i2c_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (shift_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (rx_data)
  );

endmodule

// File: tb/tb_i2c_master_read_collector.sv
// Bench for i2c_master_read_collector: table of whole transfers plus hand
// sequences for FIFO stall, abort and asynchronous reset.
module tb_i2c_master_read_collector;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic       start, abort, rb_finish, rb_load, rb_data, ack_finish, rx_ready;
  logic [7:0] byte_count;
  logic       busy, done, frame_err, rb_go, ack_go, ack_value, rx_valid;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;

  i2c_master_read_collector #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .byte_count (byte_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err),
    .rb_go      (rb_go),
    .rb_finish  (rb_finish),
    .rb_load    (rb_load),
    .rb_data    (rb_data),
    .ack_go     (ack_go),
    .ack_value  (ack_value),
    .ack_finish (ack_finish),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_shift;
  logic [7:0] last_pushed;
  int         done_cnt = 0;
  int         rb_go_cnt = 0;
  int         ack_go_cnt = 0;

  typedef struct {
    int              cnt;
    logic [2:0][7:0] b;
    int              loads0;
    logic            exp_ferr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host-side pop monitor: each accepted byte must match the oldest expected
  always @(negedge clock) begin
    if (reset_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_pop_unexpected: got %0h expected none at %0t", rx_data, $time);
      end else begin
        chk("rx_data_pop", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // Pulse counters for done / go strobes
  always @(negedge clock) begin
    if (done)   done_cnt++;
    if (rb_go)  rb_go_cnt++;
    if (ack_go) ack_go_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return rb_go;
      1:       return ack_go;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int t = 0;
    while (!sig(which) && t < 200) begin
      step();
      t++;
    end
    if (!sig(which)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got 0 expected 1 at %0t", name, $time);
    end
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    byte_count  = 8'(n);
    model_shift = 8'h00;
    step();
    start      = 1'b0;
    byte_count = 8'h00;
  endtask

  // Read-byte stage model: nloads bit strobes, rb_finish with the last one
  task automatic read_byte(input logic [7:0] b, input int nloads, input logic finish);
    wait_for(0, "rb_go");
    for (int i = 0; i < nloads; i++) begin
      if (i != 0 && $urandom_range(0, 1) == 1) step();
      rb_load     = 1'b1;
      rb_data     = b[7-i];
      rb_finish   = finish && (i == nloads - 1);
      model_shift = {model_shift[6:0], b[7-i]};
      step();
      rb_load   = 1'b0;
      rb_finish = 1'b0;
      rb_data   = 1'b0;
    end
    if (finish) begin
      exp_q.push_back(model_shift);
      last_pushed = model_shift;
    end
  endtask

  // Bit-send stage model
  task automatic do_ack(input logic exp_nack);
    wait_for(1, "ack_go");
    chk("ack_value", {31'b0, ack_value}, {31'b0, exp_nack});
    repeat ($urandom_range(0, 2)) step();
    ack_finish = 1'b1;
    step();
    ack_finish = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: got %0d expected 0 bytes left", name, exp_q.size());
    end
    step();
  endtask

  task automatic run_row(input vec_t v);
    int d0 = done_cnt;
    int g0 = rb_go_cnt;
    int a0 = ack_go_cnt;
    rx_ready = 1'b1;
    do_start(v.cnt);
    chk("ferr_clear_on_start", {31'b0, frame_err}, 32'd0);
    for (int k = 0; k < v.cnt; k++) begin
      read_byte(v.b[k], (k == 0) ? v.loads0 : 8, 1'b1);
      do_ack(k == v.cnt - 1);
    end
    wait_for(2, "done");
    step();
    step();
    chk("done_once", done_cnt - d0, 32'd1);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    chk("frame_err_end", {31'b0, frame_err}, {31'b0, v.exp_ferr});
    if (v.cnt == 0) begin
      chk("zero_len_rb_go", rb_go_cnt - g0, 32'd0);
      chk("zero_len_ack_go", ack_go_cnt - a0, 32'd0);
    end
    drain("row");
    chk("rx_valid_empty", {31'b0, rx_valid}, 32'd0);
    if (v.cnt != 0) chk("rx_data_hold", {24'b0, rx_data}, {24'b0, last_pushed});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b1, b5;
    int d0;

    vecs[0].cnt = 3; vecs[0].b[0] = 8'hA5; vecs[0].b[1] = 8'h3C; vecs[0].b[2] = 8'hFF;
    vecs[0].loads0 = 8; vecs[0].exp_ferr = 1'b0;
    vecs[1].cnt = 1; vecs[1].b[0] = 8'h5A; vecs[1].b[1] = 8'h00; vecs[1].b[2] = 8'h00;
    vecs[1].loads0 = 7; vecs[1].exp_ferr = 1'b1;
    vecs[2].cnt = 0; vecs[2].b = '0; vecs[2].loads0 = 8; vecs[2].exp_ferr = 1'b0;
    vecs[3].cnt = 2; vecs[3].b[0] = 8'h00; vecs[3].b[1] = 8'h81; vecs[3].b[2] = 8'h00;
    vecs[3].loads0 = 8; vecs[3].exp_ferr = 1'b0;
    vecs[4].cnt = 3; vecs[4].loads0 = 8; vecs[4].exp_ferr = 1'b0;
    for (int k = 0; k < 3; k++) vecs[4].b[k] = 8'($urandom_range(0, 255));

    reset_n = 1'b0; start = 1'b0; byte_count = 8'h00; abort = 1'b0;
    rb_finish = 1'b0; rb_load = 1'b0; rb_data = 1'b0; ack_finish = 1'b0; rx_ready = 1'b0;
    model_shift = 8'h00; last_pushed = 8'h00;
    repeat (3) step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_rb_go", {31'b0, rb_go}, 32'd0);
    chk("rst_ack_go", {31'b0, ack_go}, 32'd0);
    chk("rst_ack_value", {31'b0, ack_value}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // abort while idle does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", {31'b0, busy}, 32'd0);
    chk("idle_abort_done", {31'b0, done}, 32'd0);

    // FIFO full stall: six bytes with the host not ready
    rx_ready = 1'b0;
    d0 = done_cnt;
    do_start(6);
    b1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] bb;
      bb = 8'($urandom_range(0, 255));
      if (k == 0) b1 = bb;
      read_byte(bb, 8, 1'b1);
      do_ack(1'b0);
    end
    b5 = 8'($urandom_range(0, 255));
    read_byte(b5, 8, 1'b1);
    repeat (4) step();
    chk("stall_state", {29'b0, dbg_state}, {29'b0, i2c_master_read_collector_pkg::ST_STORE});
    chk("stall_no_ack", {31'b0, ack_go}, 32'd0);
    chk("stall_rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("stall_head", {24'b0, rx_data}, {24'b0, b1});
    start = 1'b1;
    byte_count = 8'h00;
    step();
    start = 1'b0;
    chk("start_ignored_busy", {31'b0, busy}, 32'd1);
    rx_ready = 1'b1;
    step();
    chk("push_on_pop_ack", {31'b0, ack_go}, 32'd1);
    do_ack(1'b0);
    read_byte(8'($urandom_range(0, 255)), 8, 1'b1);
    do_ack(1'b1);
    wait_for(2, "done");
    step();
    step();
    chk("stall_done_once", done_cnt - d0, 32'd1);
    drain("stall");

    // abort during bit 4 of byte 2
    rx_ready = 1'b0;
    d0 = done_cnt;
    do_start(3);
    b1 = 8'($urandom_range(0, 255));
    read_byte(b1, 8, 1'b1);
    do_ack(1'b0);
    read_byte(8'($urandom_range(0, 255)), 4, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_rb_go", {31'b0, rb_go}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd1);
    step();
    step();
    chk("abort_done_once", done_cnt - d0, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rx_valid", {31'b0, rx_valid}, 32'd1);
    chk("abort_head", {24'b0, rx_data}, {24'b0, b1});
    rx_ready = 1'b1;
    drain("abort");
    chk("abort_one_byte_only", {31'b0, rx_valid}, 32'd0);

    // asynchronous reset mid-READ with two bytes queued
    rx_ready = 1'b0;
    do_start(4);
    read_byte(8'($urandom_range(0, 255)), 8, 1'b1);
    do_ack(1'b0);
    read_byte(8'($urandom_range(1, 255)), 8, 1'b1);
    do_ack(1'b0);
    read_byte(8'hC3, 3, 1'b0);
    chk("pre_reset_rx_valid", {31'b0, rx_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rb_go", {31'b0, rb_go}, 32'd0);
    chk("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    run_row(vecs[0]);

    repeat (5) step();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
